uart_cmd_bridge: RTL and testbench
==================================

Name: uart_cmd_bridge

Overview:
- Byte-level command responder between the UART receiver/transmitter pair and an on-chip 8-bit register bank (Mandelbrot view/iteration parameters).
- Consumes received bytes (data + ready level), decodes write/read commands, drives the register bus, and returns one response byte per command through the transmitter's start/busy handshake.
- Includes an inter-byte timeout and a saturating error counter.

Parameters:
- AW, 4, register address width; valid addresses are 0 to 2^AW-1.
- TO_CYCLES, 240000, inter-byte timeout in clk cycles (10 ms at 24 MHz); 18-bit counter.
- ACK, 8'h06, response byte for a successful write.
- NAK, 8'h15, response byte for a bad opcode or out-of-range address.

Ports:
- clk  in  1  system clock (24 MHz)
- rst  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte; valid while rx_ready is high
- rx_ready  in  1  level from receiver; rises once per new byte, may stay high across bytes
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle transmit request
- tx_busy  in  1  transmitter busy
- reg_addr  out  AW  register address
- reg_wdata  out  8  register write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid exactly 1 cycle after reg_re
- err_cnt  out  8  saturating error count (stops at 255)

Behaviour:
- Reset (rst=0, async): state IDLE; tx_data=8'hFF; tx_start, reg_we, reg_re = 0; reg_addr, reg_wdata, err_cnt, timeout counter = 0; rx_ready_q=1.
- rx_ready_q resets to 1 so a ready level already high at reset release is not taken as a byte.
- Byte event: rx_ev = rx_ready & ~rx_ready_q; rx_ready_q <= rx_ready every cycle. rx_data is sampled only on rx_ev.
- Protocol:
  - Write: 8'h57 ('W'), addr, data -> ACK.
  - Read: 8'h52 ('R'), addr -> register value.
  - Any other opcode -> NAK immediately.
  - Address byte with any bit [7:AW] set -> NAK; for write, NAK is sent after the data byte is received.
- States:
  - IDLE: on rx_ev: 'W' -> W_ADDR; 'R' -> R_ADDR; otherwise tx_data=NAK, err_cnt++, -> SEND.
  - W_ADDR: on rx_ev, latch reg_addr and a range flag -> W_DATA.
  - R_ADDR: on rx_ev, if in range latch reg_addr -> RD, else NAK, err_cnt++, -> SEND.
  - W_DATA: on rx_ev, if in range: reg_wdata=byte, reg_we=1 for 1 cycle, tx_data=ACK, -> SEND; else NAK, err_cnt++, -> SEND.
  - RD: reg_re=1 for 1 cycle -> RD_WAIT.
  - RD_WAIT: tx_data=reg_rdata -> SEND.
  - SEND: when tx_busy=0, assert tx_start for exactly 1 cycle -> WAIT_HI; while tx_busy=1, hold in SEND.
  - WAIT_HI: wait for tx_busy=1 -> WAIT_LO.
  - WAIT_LO: wait for tx_busy=0 -> IDLE.
- Latency: the write strobe occurs 1 cycle after the data byte's rx_ev; tx_start is no earlier than the next cycle. Read: reg_re 1 cycle after the address rx_ev; tx_start 3 cycles after the address rx_ev when the transmitter is idle.
- Timeout: the counter runs only in W_ADDR, R_ADDR and W_DATA, and clears on each rx_ev and on entry. Reaching TO_CYCLES-1 -> IDLE, err_cnt++, no response sent.
- rx_ev in RD, RD_WAIT, SEND, WAIT_HI or WAIT_LO: byte is dropped, err_cnt++, state unchanged.
- rx_ev and a timeout in the same cycle: rx_ev wins and the counter clears.
- err_cnt saturates at 8'hFF; at most one increment per cycle.
- reg_addr and reg_wdata hold their last values between commands.
- Reset mid-command or mid-send forces IDLE immediately; a partial command is discarded and tx_start drops at once.

Decomposition:
- Shared package uart_pkg holds:
  - opcode constants OP_WR=8'h57, OP_RD=8'h52;
  - ACK/NAK defaults;
  - state enum;
  - DIV and TO_CYCLES defaults.
- One natural sub-module, uart_tx_hs: owns the SEND/WAIT_HI/WAIT_LO start-busy handshake and exposes send/byte/done to the decoder FSM.

Test Plan:
- Write: 57 03 A5 -> reg_we pulse with reg_addr=3 and reg_wdata=A5; tx_data=06 with one tx_start pulse; returns to IDLE after busy falls.
- Read: bank[7]=3C, send 52 07 -> reg_re pulse with addr 7; tx_data=3C transmitted; exactly one tx_start.
- Bad opcode: 41 -> NAK (15) sent, err_cnt=1. With AW=4, 57 10 FF -> no reg_we, NAK sent, err_cnt=2.
- Timeout: 57 03 then idle for TO_CYCLES cycles -> IDLE with no tx_start and err_cnt+1. A following 52 03 reads normally.
- Stale ready and overrun:
  - rx_ready held high through reset release -> no byte event.
  - A byte arriving while tx_busy=1 in WAIT_LO -> dropped, err_cnt+1.
  - tx_busy held high when entering SEND -> tx_start is deferred until busy falls.
- Async reset asserted during W_DATA and during WAIT_LO -> outputs return to reset values the same cycle; the next 52 00 completes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the UART command bridge
package uart_pkg;

  localparam logic [7:0] OP_WR         = 8'h57;
  localparam logic [7:0] OP_RD         = 8'h52;
  localparam logic [7:0] ACK_DEF       = 8'h06;
  localparam logic [7:0] NAK_DEF       = 8'h15;
  localparam int         DIV_DEF       = 208;
  localparam int         TO_CYCLES_DEF = 240000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_W_ADDR,
    ST_R_ADDR,
    ST_W_DATA,
    ST_RD,
    ST_RD_WAIT,
    ST_SEND,
    ST_WAIT_HI,
    ST_WAIT_LO
  } state_t;

  function automatic logic addr_in_range(input logic [7:0] b, input int aw);
    return (b >> aw) == 8'd0;
  endfunction

endpackage

// File: rtl/uart_tx_hs.sv
// rtl/uart_tx_hs.sv - start/busy handshake toward the UART transmitter
module uart_tx_hs
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] send_byte,
  output logic       done,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy
);

  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      tx_data <= 8'hFF;
    end else begin
      state_q <= state_d;
      if (send && state_q == ST_IDLE) tx_data <= send_byte;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (send)     state_d = ST_SEND;
      ST_SEND:    if (!tx_busy) state_d = ST_WAIT_HI;
      ST_WAIT_HI: if (tx_busy)  state_d = ST_WAIT_LO;
      ST_WAIT_LO: if (!tx_busy) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // tx_start waits out a transmitter that is still busy with an earlier byte
  always_comb begin
    tx_start = (state_q == ST_SEND) && !tx_busy;
    done     = (state_q == ST_WAIT_LO) && !tx_busy;
  end

endmodule

// File: rtl/uart_cmd_bridge.sv
// rtl/uart_cmd_bridge.sv - UART byte command decoder driving an 8-bit register bank
module uart_cmd_bridge
  import uart_pkg::*;
#(
  parameter int         AW        = 4,
  parameter int         TO_CYCLES = TO_CYCLES_DEF,
  parameter logic [7:0] ACK       = ACK_DEF,
  parameter logic [7:0] NAK       = NAK_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_busy,
  output logic [AW-1:0] reg_addr,
  output logic [7:0]    reg_wdata,
  output logic          reg_we,
  output logic          reg_re,
  input  logic [7:0]    reg_rdata,
  output logic [7:0]    err_cnt
);

  localparam logic [17:0] TO_LAST = 18'(TO_CYCLES - 1);

  state_t      state_q, state_d;
  logic        rx_ready_q, rx_ev, in_range, addr_ok;
  logic [17:0] to_cnt;
  logic        timed, to_hit;
  logic        send, hs_done, err_inc, we_set;
  logic [7:0]  send_byte;

  assign rx_ev    = rx_ready & ~rx_ready_q;
  assign in_range = addr_in_range(rx_data, AW);
  assign timed    = (state_q == ST_W_ADDR) || (state_q == ST_R_ADDR) || (state_q == ST_W_DATA);
  assign to_hit   = timed && !rx_ev && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (rx_ev) begin
          if (rx_data == OP_WR)      state_d = ST_W_ADDR;
          else if (rx_data == OP_RD) state_d = ST_R_ADDR;
          else                       state_d = ST_SEND;
        end
      ST_W_ADDR:  if (rx_ev) state_d = ST_W_DATA;
                  else if (to_hit) state_d = ST_IDLE;
      ST_R_ADDR:  if (rx_ev) state_d = in_range ? ST_RD : ST_SEND;
                  else if (to_hit) state_d = ST_IDLE;
      ST_W_DATA:  if (rx_ev) state_d = ST_SEND;
                  else if (to_hit) state_d = ST_IDLE;
      ST_RD:      state_d = ST_RD_WAIT;
      ST_RD_WAIT: state_d = ST_SEND;
      ST_SEND:    if (hs_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // ST_SEND here covers the whole handshake; bytes arriving then are overruns
  always_comb begin
    send      = 1'b0;
    send_byte = NAK;
    err_inc   = 1'b0;
    we_set    = 1'b0;
    reg_re    = (state_q == ST_RD);
    case (state_q)
      ST_IDLE:
        if (rx_ev && rx_data != OP_WR && rx_data != OP_RD) begin
          send    = 1'b1;
          err_inc = 1'b1;
        end
      ST_W_ADDR:  err_inc = to_hit;
      ST_R_ADDR:
        if (rx_ev && !in_range) begin
          send    = 1'b1;
          err_inc = 1'b1;
        end else begin
          err_inc = to_hit;
        end
      ST_W_DATA:
        if (rx_ev) begin
          send = 1'b1;
          if (addr_ok) begin
            send_byte = ACK;
            we_set    = 1'b1;
          end else begin
            err_inc = 1'b1;
          end
        end else begin
          err_inc = to_hit;
        end
      ST_RD:      err_inc = rx_ev;
      ST_RD_WAIT: begin
        send      = 1'b1;
        send_byte = reg_rdata;
        err_inc   = rx_ev;
      end
      ST_SEND:    err_inc = rx_ev;
      default:    err_inc = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ready_q <= 1'b1;
      reg_addr   <= '0;
      reg_wdata  <= 8'h00;
      reg_we     <= 1'b0;
      addr_ok    <= 1'b0;
      err_cnt    <= 8'h00;
      to_cnt     <= '0;
    end else begin
      rx_ready_q <= rx_ready;
      reg_we     <= we_set;
      if (rx_ev && (state_q == ST_W_ADDR || (state_q == ST_R_ADDR && in_range)))
        reg_addr <= rx_data[AW-1:0];
      if (rx_ev && state_q == ST_W_ADDR) addr_ok <= in_range;
      if (we_set) reg_wdata <= rx_data;
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      to_cnt <= (rx_ev || !timed) ? '0 : to_cnt + 18'd1;
    end
  end

  uart_tx_hs u_tx_hs (
    .clk       (clk),
    .rst       (rst),
    .send      (send),
    .send_byte (send_byte),
    .done      (hs_done),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy)
  );

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// tb/tb_uart_cmd_bridge.sv - directed vector bench for uart_cmd_bridge
module tb_uart_cmd_bridge;

  localparam int AW = 4;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = 8'h41;
  logic          rx_ready = 1'b1;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_we;
  logic          reg_re;
  logic [7:0]    reg_rdata = 8'h00;
  logic [7:0]    err_cnt;

  logic       auto_tx = 1'b1;
  logic       man_busy = 1'b0;
  logic [2:0] tcnt;
  logic [7:0] last_tx = 8'h00;
  int         tx_cnt = 0, we_cnt = 0, re_cnt = 0;
  int         checks = 0, failures = 0, exp_err = 0;
  logic [7:0] bank [16] = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    logic [7:0] tx;
    int         we, re, err;
  } vec_t;
  vec_t vecs [8];

  uart_cmd_bridge #(.AW(AW), .TO_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  assign tx_busy = auto_tx ? (tcnt != 3'd0) : man_busy;

  // transmitter model: busy for four cycles after each accepted start
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt <= 3'd0;
    end else if (tx_start) begin
      tcnt    <= 3'd4;
      tx_cnt  <= tx_cnt + 1;
      last_tx <= tx_data;
    end else if (tcnt != 3'd0) begin
      tcnt <= tcnt - 3'd1;
    end
  end

  always @(posedge clk) begin
    if (reg_we) begin
      bank[reg_addr] <= reg_wdata;
      we_cnt         <= we_cnt + 1;
    end
    if (reg_re) begin
      reg_rdata <= bank[reg_addr];
      re_cnt    <= re_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply(input vec_t v, input string name);
    int t0, w0, r0;
    t0 = tx_cnt; w0 = we_cnt; r0 = re_cnt;
    send_rx(v.b0);
    if (v.n > 1) send_rx(v.b1);
    if (v.n > 2) send_rx(v.b2);
    idle(12);
    exp_err += v.err;
    chk({name, " tx_starts"}, tx_cnt - t0, 1);
    chk({name, " tx_byte"}, last_tx, v.tx);
    chk({name, " we_pulses"}, we_cnt - w0, v.we);
    chk({name, " re_pulses"}, re_cnt - r0, v.re);
    chk({name, " err_cnt"}, err_cnt, exp_err);
    if (v.we != 0) begin
      chk({name, " reg_addr"}, reg_addr, v.b1[AW-1:0]);
      chk({name, " reg_wdata"}, reg_wdata, v.b2);
    end
  endtask

  initial begin
    int t0, w0;
    vecs[0] = '{8'h57, 8'h03, 8'hA5, 3, 8'h06, 1, 0, 0};
    vecs[1] = '{8'h52, 8'h03, 8'h00, 2, 8'hA5, 0, 1, 0};
    vecs[2] = '{8'h52, 8'h07, 8'h00, 2, 8'h3C, 0, 1, 0};
    vecs[3] = '{8'h41, 8'h00, 8'h00, 1, 8'h15, 0, 0, 1};
    vecs[4] = '{8'h57, 8'h10, 8'hFF, 3, 8'h15, 0, 0, 1};
    vecs[5] = '{8'h52, 8'h1F, 8'h00, 2, 8'h15, 0, 0, 1};
    vecs[6] = '{8'h57, 8'h0F, 8'h5A, 3, 8'h06, 1, 0, 0};
    vecs[7] = '{8'h52, 8'h0F, 8'h00, 2, 8'h5A, 0, 1, 0};

    // reset values, with a stale ready level held through reset release
    idle(3);
    chk("rst tx_data", tx_data, 8'hFF);
    chk("rst tx_start", tx_start, 0);
    chk("rst reg_we", reg_we, 0);
    chk("rst reg_re", reg_re, 0);
    chk("rst reg_addr", reg_addr, 0);
    chk("rst reg_wdata", reg_wdata, 0);
    chk("rst err_cnt", err_cnt, 0);
    rst = 1'b1;
    idle(5);
    chk("stale ready err_cnt", err_cnt, 0);
    chk("stale ready tx_starts", tx_cnt, 0);
    rx_ready = 1'b0;
    idle(2);

    for (int i = 0; i < 8; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // read latency: reg_re one cycle after address event, tx_start three cycles after
    send_rx(8'h52);
    @(negedge clk); rx_data = 8'h07; rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0;
    chk("lat reg_re c1", reg_re, 1);
    chk("lat reg_addr", reg_addr, 7);
    @(negedge clk);
    chk("lat reg_re c2", reg_re, 0);
    chk("lat tx_start c2", tx_start, 0);
    @(negedge clk);
    chk("lat tx_start c3", tx_start, 1);
    chk("lat tx_data", tx_data, 8'h3C);
    idle(12);

    // inter-byte timeout in W_DATA
    t0 = tx_cnt; w0 = we_cnt;
    send_rx(8'h57);
    send_rx(8'h03);
    idle(TO - 10);
    chk("to early err_cnt", err_cnt, exp_err);
    idle(15);
    exp_err++;
    chk("to err_cnt", err_cnt, exp_err);
    chk("to tx_starts", tx_cnt - t0, 0);
    chk("to we_pulses", we_cnt - w0, 0);
    apply('{8'h52, 8'h03, 8'h00, 2, 8'hA5, 0, 1, 0}, "after_to");

    // overrun while waiting for busy to fall
    auto_tx = 1'b0; man_busy = 1'b0;
    t0 = tx_cnt;
    send_rx(8'h41);
    man_busy = 1'b1;
    idle(2);
    send_rx(8'h52);
    man_busy = 1'b0;
    idle(3);
    auto_tx = 1'b1;
    exp_err += 2;
    chk("ovr err_cnt", err_cnt, exp_err);
    chk("ovr tx_starts", tx_cnt - t0, 1);
    chk("ovr tx_byte", last_tx, 8'h15);
    apply('{8'h52, 8'h03, 8'h00, 2, 8'hA5, 0, 1, 0}, "after_ovr");

    // busy already high when SEND is entered
    auto_tx = 1'b0; man_busy = 1'b1;
    t0 = tx_cnt;
    send_rx(8'h41);
    idle(4);
    chk("defer tx_starts", tx_cnt - t0, 0);
    chk("defer tx_start held", tx_start, 0);
    man_busy = 1'b0;
    #1;
    chk("defer tx_start release", tx_start, 1);
    @(negedge clk); man_busy = 1'b1;
    idle(2);
    man_busy = 1'b0;
    idle(3);
    auto_tx = 1'b1;
    exp_err++;
    chk("defer tx_starts after", tx_cnt - t0, 1);
    chk("defer err_cnt", err_cnt, exp_err);

    // async reset during W_DATA
    send_rx(8'h57);
    send_rx(8'h05);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rstw tx_data", tx_data, 8'hFF);
    chk("rstw reg_we", reg_we, 0);
    chk("rstw reg_addr", reg_addr, 0);
    chk("rstw reg_wdata", reg_wdata, 0);
    chk("rstw err_cnt", err_cnt, 0);
    exp_err = 0;
    @(negedge clk); rst = 1'b1;
    idle(2);
    apply('{8'h52, 8'h00, 8'h00, 2, 8'h11, 0, 1, 0}, "after_rstw");

    // async reset during WAIT_LO
    auto_tx = 1'b0; man_busy = 1'b0;
    send_rx(8'h41);
    man_busy = 1'b1;
    idle(2);
    chk("rstl pre err_cnt", err_cnt, 1);
    chk("rstl pre tx_data", tx_data, 8'h15);
    rst = 1'b0;
    #1;
    chk("rstl tx_data", tx_data, 8'hFF);
    chk("rstl tx_start", tx_start, 0);
    chk("rstl err_cnt", err_cnt, 0);
    exp_err = 0;
    @(negedge clk); rst = 1'b1; man_busy = 1'b0; auto_tx = 1'b1;
    idle(2);
    apply('{8'h52, 8'h00, 8'h00, 2, 8'h11, 0, 1, 0}, "after_rstl");

    // error counter saturation
    for (int i = 0; i < 255; i++) begin
      send_rx(8'h41);
      idle(8);
    end
    chk("sat err_cnt 255", err_cnt, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      send_rx(8'h41);
      idle(8);
    end
    chk("sat err_cnt held", err_cnt, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
